// File: rtl/regfile_dump.sv
// regfile_dump: parametrised two-read-port register file with write-first
// bypass, optional hardwired zero register and a streaming debug-dump port.
//
// Dump handshake: a word is transferred on a rising edge where
// dump_valid && dump_ready are both high; while dump_valid is high and
// dump_ready is low, dump_idx/dump_data hold their values (a snapshot taken
// when the word was loaded, unaffected by later writes to that register).
module regfile_dump #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] bank [DEPTH];
    logic [ADDR_W-1:0] idx_nx;
    logic [ADDR_W-1:0] idx_inc;
    logic [DATA_W-1:0] data_nx;
    logic              done_nx;
    logic              wr_ok;

    // Register 0 swallows writes when it is hardwired to zero.
    assign wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign idx_inc = dump_idx + ADDR_W'(1);

    // Value a read of address a returns this cycle, including the write bypass.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a);
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        else if (wr_en && (wr_addr == a))
            return wr_data;
        else
            return bank[a];
    endfunction

    // Register bank: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (wr_ok) begin
            bank[wr_addr] <= wr_data;
        end
    end

    // Registered read ports with same-edge write forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            rd_data1 <= fwd(rd_addr1);
            rd_data2 <= fwd(rd_addr2);
        end
    end

    // Dump FSM state and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_nx;
            dump_idx  <= idx_nx;
            dump_data <= data_nx;
            dump_done <= done_nx;
        end
    end

    // Dump FSM next state: load word 0 on start, advance on each accept.
    always_comb begin
        state_nx   = state;
        idx_nx     = dump_idx;
        data_nx    = dump_data;
        done_nx    = 1'b0;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                    data_nx  = fwd('0);
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx  = idx_inc;
                        data_nx = fwd(idx_inc);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
